// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive packetizer.
package uart_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      PAYLOAD,
      CSUM,
      DRAIN
   } state_t;

   localparam byte_t SYNC_BYTE_DEF = 8'hA5;

   // Width able to hold every legal LEN value 0..depth.
   function automatic int idx_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/uart_rx_packetizer_if.sv
// Payload stream from the packetizer to its consumer (valid/ready with last marker).
interface uart_rx_packetizer_if;
   import uart_pkg::*;

   byte_t data;
   logic  valid;
   logic  last;
   logic  ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/uart_pkt_buf.sv
// Payload store: registered write port, combinational read port, no reset on storage.
module uart_pkt_buf
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  byte_t         wdata,
   input  logic [AW-1:0] raddr,
   output byte_t         rdata
);

   byte_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_packetizer.sv
// Frames SYNC/LEN/payload/CSUM from the UART byte stream, checks the checksum and
// replays the payload downstream; resets the receiver on timeout or bad length.
module uart_rx_packetizer
   import uart_pkg::*;
#(
   parameter int    MAX_LEN        = 16,
   parameter byte_t SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int    TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  byte_t                rx_data,
   input  logic                 rx_ready,
   output logic                 rx_reset,
   uart_rx_packetizer_if.master pkt,
   output logic                 pkt_ok,
   output logic                 err_crc,
   output logic                 err_len,
   output logic                 err_timeout,
   output logic                 err_overflow
);

   localparam int               IDX_W     = idx_width(MAX_LEN);
   localparam int               AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int               CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam byte_t            MAX_LEN_B = byte_t'(MAX_LEN);

   state_t           state, state_n;
   logic [IDX_W-1:0] len_q, len_n;
   logic [IDX_W-1:0] wr_idx, wr_n;
   logic [IDX_W-1:0] rd_idx, rd_n;
   logic [CNT_W-1:0] idle_cnt, idle_n;
   byte_t            sum_q, sum_n;
   byte_t            csum_chk;
   byte_t            rdata;
   logic             we;
   logic             valid;
   logic             last;
   logic             in_frame;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         wr_idx   <= '0;
         rd_idx   <= '0;
         idle_cnt <= '0;
      end else begin
         state    <= state_n;
         wr_idx   <= wr_n;
         rd_idx   <= rd_n;
         idle_cnt <= idle_n;
      end
   end

   // Length and running sum are only read in states that first write them.
   always_ff @(posedge clk) begin
      len_q <= len_n;
      sum_q <= sum_n;
   end

   assign csum_chk = sum_q + rx_data;
   assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CSUM);

   always_comb begin
      state_n      = state;
      len_n        = len_q;
      wr_n         = wr_idx;
      rd_n         = rd_idx;
      sum_n        = sum_q;
      idle_n       = '0;
      we           = 1'b0;
      valid        = 1'b0;
      last         = 1'b0;
      rx_reset     = 1'b0;
      pkt_ok       = 1'b0;
      err_crc      = 1'b0;
      err_len      = 1'b0;
      err_timeout  = 1'b0;
      err_overflow = 1'b0;

      // A byte arriving on the expiry cycle beats the timeout.
      if (in_frame && !rx_ready) begin
         if (idle_cnt == IDLE_LAST) begin
            err_timeout = 1'b1;
            rx_reset    = 1'b1;
            state_n     = IDLE;
         end else begin
            idle_n = idle_cnt + CNT_W'(1);
         end
      end

      unique case (state)
         IDLE: begin
            if (rx_ready && (rx_data == SYNC_BYTE)) begin
               state_n = LEN;
            end
         end
         LEN: begin
            if (rx_ready) begin
               if (rx_data > MAX_LEN_B) begin
                  err_len  = 1'b1;
                  rx_reset = 1'b1;
                  state_n  = IDLE;
               end else begin
                  len_n   = IDX_W'(rx_data);
                  sum_n   = rx_data;
                  wr_n    = '0;
                  state_n = (rx_data == 8'h00) ? CSUM : PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (rx_ready) begin
               we    = 1'b1;
               wr_n  = wr_idx + IDX_W'(1);
               sum_n = sum_q + rx_data;
               if (wr_n == len_q) begin
                  state_n = CSUM;
               end
            end
         end
         CSUM: begin
            if (rx_ready) begin
               if (csum_chk == 8'h00) begin
                  pkt_ok  = 1'b1;
                  rd_n    = '0;
                  state_n = (len_q != '0) ? DRAIN : IDLE;
               end else begin
                  err_crc = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         DRAIN: begin
            valid        = 1'b1;
            last         = (rd_idx == (len_q - IDX_W'(1)));
            err_overflow = rx_ready;
            if (pkt.ready) begin
               rd_n = rd_idx + IDX_W'(1);
               if (last) begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   uart_pkt_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (we),
      .waddr (wr_idx[AW-1:0]),
      .wdata (rx_data),
      .raddr (rd_idx[AW-1:0]),
      .rdata (rdata)
   );

   assign pkt.data  = rdata;
   assign pkt.valid = valid;
   assign pkt.last  = last;

endmodule

// File: doc/uart_rx_packetizer.md
Name: uart_rx_packetizer

Overview:
- Sequences the byte stream from the UART receiver into checksummed packets.
- Frame format: SYNC, LEN, LEN payload bytes, CSUM.
- Buffers the payload, validates the checksum, then releases the payload downstream over a valid/ready stream.
- Supervises the receiver: on inter-byte timeout or framing error it pulses the receiver's reset to force resynchronisation.

Parameters:
- MAX_LEN, 16: payload buffer depth in bytes; legal LEN is 0..MAX_LEN.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 1024: clk cycles allowed between consecutive bytes inside a frame.

Ports:
- clk  input  1  sample clock, shared with the UART receiver.
- reset_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte; valid only when rx_ready=1.
- rx_ready  input  1  one-cycle strobe from the receiver per byte.
- rx_reset  output  1  one-cycle pulse to the receiver's reset input.
- pkt_data  output  8  payload byte.
- pkt_valid  output  1  pkt_data valid.
- pkt_last  output  1  final payload byte of the packet; qualified by pkt_valid.
- pkt_ready  input  1  downstream accept.
- pkt_ok  output  1  one-cycle pulse: frame passed the checksum.
- err_crc  output  1  one-cycle pulse: checksum mismatch.
- err_len  output  1  one-cycle pulse: LEN > MAX_LEN.
- err_timeout  output  1  one-cycle pulse: inter-byte timeout.
- err_overflow  output  1  one-cycle pulse: byte dropped during DRAIN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, counters 0. Buffer contents are don't-care.
- States:
  - IDLE: rx_ready with rx_data==SYNC_BYTE -> LEN. Any other byte is ignored.
  - LEN: on a byte:
    - >MAX_LEN -> err_len + rx_reset pulse -> IDLE.
    - ==0 -> CSUM.
    - else store the length, sum=byte -> PAYLOAD.
  - PAYLOAD: each byte is written to buf[wr_idx], wr_idx++, sum+=byte. After LEN bytes -> CSUM.
  - CSUM: on a byte, (sum+byte) mod 256 is checked:
    - ==0: pkt_ok pulse; LEN>0 -> DRAIN, LEN==0 -> IDLE.
    - else: err_crc pulse -> IDLE. No rx_reset on a checksum error.
  - DRAIN: pkt_valid=1, pkt_data=buf[rd_idx], pkt_last=(rd_idx==LEN-1).
    - Advance on pkt_valid&&pkt_ready.
    - The transfer with pkt_last -> IDLE; pkt_valid drops the next cycle.
- Latency: pkt_valid rises exactly one cycle after the rx_ready cycle of the CSUM byte.
- Sum is 8-bit and wraps modulo 256.
- Stream rules:
  - pkt_data and pkt_last are stable while pkt_valid && !pkt_ready.
  - pkt_valid never deasserts without a transfer.
- DRAIN overflow: the receiver has no backpressure, so every rx_ready seen in DRAIN drops the byte and pulses err_overflow. That includes SYNC_BYTE, which is not recognised. Buffer and rd_idx are unaffected.
- Timeout:
  - In LEN, PAYLOAD and CSUM, idle_cnt increments each cycle and clears on rx_ready.
  - idle_cnt==TIMEOUT_CYCLES-1 without rx_ready -> err_timeout + rx_reset pulse -> IDLE.
  - rx_ready in the expiry cycle wins: the byte is processed and there is no timeout.
  - idle_cnt is held at 0 in IDLE and DRAIN.
- Simultaneous events: error pulses and pkt_ok are mutually exclusive by construction; at most one per cycle.
- Reset mid-frame or mid-drain: frame discarded, pkt_valid drops immediately (async), no error pulse.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, LEN, PAYLOAD, CSUM, DRAIN);
  - SYNC_BYTE default;
  - index width clog2(MAX_LEN+1);
  - byte type.
- One sub-module: uart_pkt_buf.
  - MAX_LEN x 8 register buffer.
  - Write port: we, waddr, wdata.
  - Combinational read port: raddr -> rdata.
  - No reset on storage.
- FSM, checksum and timeout logic stay in the top module.

Test Plan:
- Good frame: send A5 03 11 22 33 97, pkt_ready=1 -> pkt_ok pulse; pkt_data 11,22,33 on consecutive cycles starting one cycle after the 97 strobe; pkt_last only with 33.
- Bad checksum: A5 03 11 22 33 00 -> err_crc one cycle, pkt_valid never asserts, rx_reset stays 0. Then A5 01 5A A5 -> pkt_ok, single byte 5A with pkt_last.
- Length and empty frames:
  - A5 20 -> err_len + rx_reset pulse on the same cycle, state IDLE.
  - A5 00 00 -> pkt_ok with no pkt_valid.
  - Junk 00 FF 11 before A5 is ignored.
- Timeout: A5 02 11, then silence -> err_timeout + rx_reset exactly 1024 cycles after the 11 strobe. A strobe delivered on cycle 1023 instead is accepted with no error.
- Backpressure and overflow: good 3-byte frame with pkt_ready=0 for 50 cycles, injecting strobes A5 and 44 -> two err_overflow pulses, pkt_data held at 11. Release pkt_ready -> 11,22,33 delivered intact.
- Reset mid-operation: assert reset_n=0 mid-PAYLOAD and mid-DRAIN -> all outputs 0 asynchronously. After release, a fresh good frame is delivered correctly.
